// File: rtl/udp_frame_tx.sv
// UDP datagram serializer: emits an 8-byte big-endian UDP header from a
// registered descriptor, then passes the payload through. With CHECK_LENGTH
// set, the payload is trimmed or flagged against the header length field.
module udp_frame_tx #(
  parameter bit CHECK_LENGTH = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hdr_valid,
  output logic        hdr_ready,
  input  logic [15:0] hdr_src_port,
  input  logic [15:0] hdr_dst_port,
  input  logic [15:0] hdr_length,
  input  logic [15:0] hdr_checksum,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic        len_error
);

  localparam int unsigned HDR_LEN = 8;

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, DRAIN} state_t;

  state_t      state_q;
  logic [15:0] src_q, dst_q, len_q, csum_q;
  logic [15:0] exp_q, exp_d;
  logic        short_q, short_d;
  logic [2:0]  idx_q;
  logic [15:0] cnt_q, cnt_d;
  logic        rdy_q;
  logic        err_q;
  logic [7:0]  hdr_byte;
  logic        pay_last;
  logic        m_xfer;

  // Expected payload count from the incoming descriptor; short lengths map to zero
  always_comb begin
    short_d = (hdr_length < 16'(HDR_LEN));
    exp_d   = short_d ? 16'd0 : (hdr_length - 16'(HDR_LEN));
    cnt_d   = cnt_q + 16'd1;
    pay_last = (cnt_d == exp_q);
  end

  // Select the current header byte, most significant byte of each field first
  always_comb begin
    hdr_byte = 8'h00;
    case (idx_q)
      3'd0: hdr_byte = src_q[15:8];
      3'd1: hdr_byte = src_q[7:0];
      3'd2: hdr_byte = dst_q[15:8];
      3'd3: hdr_byte = dst_q[7:0];
      3'd4: hdr_byte = len_q[15:8];
      3'd5: hdr_byte = len_q[7:0];
      3'd6: hdr_byte = csum_q[15:8];
      3'd7: hdr_byte = csum_q[7:0];
      default: hdr_byte = 8'h00;
    endcase
  end

  // Output steering per state; payload is a combinational pass-through
  always_comb begin
    m_axis_tdata  = 8'h00;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = 1'b0;
    case (state_q)
      HEADER: begin
        m_axis_tdata  = hdr_byte;
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = (idx_q == 3'd7) && (exp_q == 16'd0);
      end
      PAYLOAD: begin
        m_axis_tdata  = s_axis_tdata;
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tlast  = s_axis_tlast | (CHECK_LENGTH & pay_last);
        s_axis_tready = m_axis_tready;
      end
      DRAIN: s_axis_tready = 1'b1;
      default: ;
    endcase
    m_xfer    = m_axis_tvalid && m_axis_tready;
    hdr_ready = rdy_q;
    len_error = err_q;
  end

  // Datagram sequencing, field capture, counters and the error pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      csum_q  <= '0;
      exp_q   <= '0;
      short_q <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (hdr_valid && rdy_q) begin
            src_q   <= hdr_src_port;
            dst_q   <= hdr_dst_port;
            len_q   <= hdr_length;
            csum_q  <= hdr_checksum;
            exp_q   <= exp_d;
            short_q <= short_d;
            idx_q   <= '0;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
            state_q <= HEADER;
          end else begin
            rdy_q <= 1'b1;
          end
        end
        HEADER: begin
          if (m_xfer) begin
            idx_q <= idx_q + 3'd1;
            if (idx_q == 3'd7) begin
              if (exp_q == 16'd0) begin
                err_q   <= CHECK_LENGTH & short_q;
                rdy_q   <= 1'b1;
                state_q <= IDLE;
              end else begin
                state_q <= PAYLOAD;
              end
            end
          end
        end
        PAYLOAD: begin
          if (m_xfer) begin
            cnt_q <= cnt_d;
            if (CHECK_LENGTH) begin
              if (pay_last) begin
                if (s_axis_tlast) begin
                  rdy_q   <= 1'b1;
                  state_q <= IDLE;
                end else begin
                  err_q   <= 1'b1;
                  state_q <= DRAIN;
                end
              end else if (s_axis_tlast) begin
                err_q   <= 1'b1;
                rdy_q   <= 1'b1;
                state_q <= IDLE;
              end
            end else if (s_axis_tlast) begin
              rdy_q   <= 1'b1;
              state_q <= IDLE;
            end
          end
        end
        DRAIN: begin
          if (s_axis_tvalid && s_axis_tlast) begin
            rdy_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_frame_tx.sv
// Scoreboard bench for udp_frame_tx: randomized datagrams against a
// length-rule reference model, plus directed cases and a mid-header reset.
module tb_udp_frame_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        hdr_valid = 1'b0;
  logic        hdr_ready;
  logic [15:0] hdr_src_port = '0, hdr_dst_port = '0, hdr_length = '0, hdr_checksum = '0;
  logic [7:0]  s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0;
  logic        s_axis_tready;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tlast;
  logic        m_axis_tready = 1'b1;
  logic        len_error;

  always #5 clk = ~clk;

  udp_frame_tx #(.CHECK_LENGTH(1'b1)) dut (
    .clk(clk), .reset(reset),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
    .hdr_src_port(hdr_src_port), .hdr_dst_port(hdr_dst_port),
    .hdr_length(hdr_length), .hdr_checksum(hdr_checksum),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .len_error(len_error)
  );

  int tests = 0;
  int fails = 0;
  logic [8:0] exp_q[$];
  logic [7:0] pay[$];
  int err_seen = 0;
  int srdy_seen = 0;
  int pops = 0;
  bit rnd_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Downstream back-pressure
  initial forever begin
    @(posedge clk);
    #1;
    m_axis_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: pops the scoreboard on every output transfer, checks stall stability
  initial begin
    bit         prev_stall = 1'b0;
    logic [8:0] prev = '0;
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", 32'(m_axis_tvalid), 32'd1);
          check("stall_data", 32'({m_axis_tlast, m_axis_tdata}), 32'(prev));
        end
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_q.size() == 0) begin
            timeout_fail("unexpected_output");
          end else begin
            e = exp_q.pop_front();
            check("out_byte", 32'({m_axis_tlast, m_axis_tdata}), 32'(e));
            pops++;
          end
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev = {m_axis_tlast, m_axis_tdata};
        if (len_error) err_seen++;
        if (s_axis_tready) srdy_seen++;
      end
    end
  end

  task automatic push_header(input logic [15:0] src, input logic [15:0] dst,
                             input logic [15:0] len, input logic [15:0] csum, input bit last7);
    logic [63:0] h;
    h = {src, dst, len, csum};
    for (int i = 0; i < 8; i++)
      exp_q.push_back({(last7 && i == 7), h[63 - 8 * i -: 8]});
  endtask

  task automatic send_hdr(input logic [15:0] src, input logic [15:0] dst,
                          input logic [15:0] len, input logic [15:0] csum);
    int budget;
    @(posedge clk);
    #1;
    hdr_src_port = src; hdr_dst_port = dst; hdr_length = len; hdr_checksum = csum;
    hdr_valid = 1'b1;
    budget = 200;
    forever begin
      @(negedge clk);
      if (hdr_ready) break;
      budget--;
      if (budget == 0) begin timeout_fail("hdr_accept"); break; end
    end
    @(posedge clk);
    #1;
    hdr_valid = 1'b0;
  endtask

  // Reference model: header always, then min(n, expected) payload bytes; tlast on the final one
  task automatic send_dgram(input logic [15:0] src, input logic [15:0] dst,
                            input logic [15:0] len, input logic [15:0] csum);
    int n, expn, nout, e0, s0, budget;
    bit exp_err;
    n = pay.size();
    expn = (int'(len) < 8) ? 0 : int'(len) - 8;
    nout = (n < expn) ? n : expn;
    exp_err = (expn == 0) ? (int'(len) < 8) : (n != expn);
    push_header(src, dst, len, csum, expn == 0);
    for (int k = 0; k < nout; k++) exp_q.push_back({(k == nout - 1), pay[k]});
    e0 = err_seen;
    s0 = srdy_seen;
    send_hdr(src, dst, len, csum);
    if (expn > 0) begin
      for (int k = 0; k < n; k++) begin
        s_axis_tdata = pay[k];
        s_axis_tlast = (k == n - 1);
        s_axis_tvalid = 1'b1;
        budget = 200;
        forever begin
          @(negedge clk);
          if (s_axis_tready) break;
          budget--;
          if (budget == 0) begin timeout_fail("payload_accept"); break; end
        end
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        if (k != n - 1 && $urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
      end
      @(negedge clk);
      check("ready_after_end", 32'(hdr_ready), 32'd1);
    end
    budget = 300;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && hdr_ready) break;
      budget--;
      if (budget == 0) begin timeout_fail("dgram_done"); exp_q.delete(); break; end
    end
    @(negedge clk);
    #1;
    check("len_error_count", 32'(err_seen - e0), 32'(exp_err));
    if (expn == 0) check("no_payload_ready", 32'(srdy_seen - s0), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'd0);
    check({tag, "_tlast"}, 32'(m_axis_tlast), 32'd0);
    check({tag, "_tdata"}, 32'(m_axis_tdata), 32'd0);
    check({tag, "_s_tready"}, 32'(s_axis_tready), 32'd0);
    check({tag, "_hdr_ready"}, 32'(hdr_ready), 32'd0);
    check({tag, "_len_error"}, 32'(len_error), 32'd0);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("hdr_ready_before_edge", 32'(hdr_ready), 32'd0);
    @(negedge clk);
    check("hdr_ready_after_edge", 32'(hdr_ready), 32'd1);
  endtask

  initial begin
    int p0, budget, len, n;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    release_reset();

    // Directed datagrams with free-flowing output
    pay = '{8'hA5};
    send_dgram(16'h1234, 16'h0050, 16'h0009, 16'hBEEF);
    pay.delete();
    send_dgram(16'h1234, 16'h0050, 16'h0008, 16'hBEEF);
    pay = '{8'h11, 8'h22};
    send_dgram(16'hAAAA, 16'h5555, 16'h000C, 16'h0F0F);
    pay = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_dgram(16'h0102, 16'h0304, 16'h000A, 16'h0506);
    pay.delete();
    send_dgram(16'hCAFE, 16'hF00D, 16'h0005, 16'h1111);

    // Same first datagram under random back-pressure
    rnd_ready = 1'b1;
    pay = '{8'hA5};
    send_dgram(16'h1234, 16'h0050, 16'h0009, 16'hBEEF);

    // Reset while header byte 3 is on the output
    rnd_ready = 1'b0;
    push_header(16'h1234, 16'h0050, 16'h0009, 16'hBEEF, 1'b0);
    p0 = pops;
    send_hdr(16'h1234, 16'h0050, 16'h0009, 16'hBEEF);
    budget = 100;
    while (pops < p0 + 3 && budget > 0) begin
      @(negedge clk);
      #1;
      budget--;
    end
    if (budget == 0) timeout_fail("reach_byte3");
    #6;
    check("byte3_before_reset", 32'(m_axis_tdata), 32'h50);
    reset = 1'b1;
    #1;
    check_idle_outputs("async_reset");
    exp_q.delete();
    @(negedge clk);
    check("reset_hold_tvalid", 32'(m_axis_tvalid), 32'd0);
    release_reset();
    pay = '{8'hA5};
    send_dgram(16'h1234, 16'h0050, 16'h0009, 16'hBEEF);

    // Randomized datagrams under random back-pressure
    rnd_ready = 1'b1;
    for (int t = 0; t < 40; t++) begin
      len = $urandom_range(0, 24);
      n = (len <= 8) ? 0 : $urandom_range(1, len - 8 + 3);
      pay.delete();
      for (int k = 0; k < n; k++) pay.push_back(8'($urandom));
      send_dgram(16'($urandom), 16'($urandom), 16'(len), 16'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
